// File: rtl/reg_write_queue_if.sv
// Handshake and status bundle between a producer and the register write queue.
// master: producer/drain-control side; slave: the queue itself.
// The parameters must match the ones given to reg_write_queue.
interface reg_write_queue_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
);
    // producer side
    logic                    in_valid;
    logic [DATA_WIDTH-1:0]   in_data;
    logic                    in_ready;

    // downstream register side
    logic                    drain_en;
    logic                    write_enable;
    logic [DATA_WIDTH-1:0]   write_port_1;

    // status
    logic                    full;
    logic                    empty;
    logic [$clog2(DEPTH):0]  count;
    logic                    clr_overflow;
    logic                    overflow;

    modport master (
        output in_valid, in_data, drain_en, clr_overflow,
        input  in_ready, write_enable, write_port_1, full, empty, count, overflow
    );

    modport slave (
        input  in_valid, in_data, drain_en, clr_overflow,
        output in_ready, write_enable, write_port_1, full, empty, count, overflow
    );
endinterface

// File: rtl/reg_write_queue.sv
// Purpose: FIFO of words waiting to be written into a downstream register; optional sticky overflow flag (WRQ_OVERFLOW_FLAG_EN).
// Latency: a word pushed at edge N is presented on write_port_1 from cycle N+1; no same-cycle bypass.
// Backpressure: in_ready = !full; words offered while full are dropped; popping only when drain_en and not empty.
module reg_write_queue #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic           clk,
    input  logic           reset,
    reg_write_queue_if.slave q
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // Parameter legality is checked at elaboration so bad builds stop early.
    if (DATA_WIDTH < 8 || DATA_WIDTH > 32) begin : g_bad_width
        $error("reg_write_queue: DATA_WIDTH must be in 8..32");
    end
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("reg_write_queue: DEPTH must be a power of two in 2..16");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      cnt;

    logic                  full_int;
    logic                  empty_int;
    logic                  push;
    logic                  pop;

    // Flags come straight from the registered count.
    assign full_int  = (cnt == CNT_FULL);
    assign empty_int = (cnt == '0);

    // A full queue refuses the word; an empty queue ignores drain_en.
    assign push = q.in_valid && !full_int;
    assign pop  = q.drain_en && !empty_int;

    assign q.in_ready     = !full_int;
    assign q.write_enable = pop;
    assign q.full         = full_int;
    assign q.empty        = empty_int;
    assign q.count        = cnt;
    // Drive zero when empty so the downstream bus never shows stale data.
    assign q.write_port_1 = empty_int ? '0 : mem[rd_ptr];

    // Storage write; contents are don't-care until a push lands, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= q.in_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Occupancy: simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

`ifdef WRQ_OVERFLOW_FLAG_EN
    logic overflow_q;

    // Sticky overflow: a rejected offer sets it, clear only wins when no new overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (q.in_valid && full_int) begin
            overflow_q <= 1'b1;
        end else if (q.clr_overflow) begin
            overflow_q <= 1'b0;
        end
    end

    assign q.overflow = overflow_q;
`else
    // Feature compiled out: the clear input is accepted but has no effect.
    logic unused_clr_overflow;
    assign unused_clr_overflow = q.clr_overflow;
    assign q.overflow          = 1'b0;
`endif

endmodule

// File: tb/tb_reg_write_queue.sv
// Randomised plus directed bench for reg_write_queue with a queue-based reference model.
// Model updates at posedge from the offered inputs; monitor checks at negedge against the scoreboard.
module tb_reg_write_queue;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;

    reg_write_queue_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    reg_write_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: words still held (scoreboard), occupancy, sticky flag.
    logic [DW-1:0] sb[$];
    int            occ = 0;
    bit            ovf = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: decide push/pop from the rules, record accepted words.
    always @(posedge clk) begin
        if (!reset) begin
            bit do_push;
            bit do_pop;
            do_pop  = (occ > 0) && bus.drain_en;
            do_push = bus.in_valid && (occ < DEPTH);
`ifdef WRQ_OVERFLOW_FLAG_EN
            if (bus.in_valid && occ == DEPTH) ovf = 1'b1;
            else if (bus.clr_overflow)        ovf = 1'b0;
`endif
            if (do_push) sb.push_back(bus.in_data);
            occ = occ + int'(do_push) - int'(do_pop);
        end
    end

    // Monitor: compare status every cycle, consume scoreboard on each write strobe.
    always @(negedge clk) begin
        check("count",     32'(bus.count),        32'(occ));
        check("full",      32'(bus.full),         32'(occ == DEPTH));
        check("empty",     32'(bus.empty),        32'(occ == 0));
        check("in_ready",  32'(bus.in_ready),     32'(occ != DEPTH));
        check("write_en",  32'(bus.write_enable), 32'((occ > 0) && bus.drain_en));
        check("overflow",  32'(bus.overflow),     32'(ovf));
        if (occ == 0) begin
            check("port_empty", 32'(bus.write_port_1), 32'h0);
        end
        if (bus.write_enable === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                check("drain_data", 32'(bus.write_port_1), 32'(sb.pop_front()));
            end
        end else if (occ > 0 && sb.size() > 0) begin
            check("head_data", 32'(bus.write_port_1), 32'(sb[0]));
        end
    end

    // One clock cycle of stimulus, applied just after the active edge.
    task automatic cyc(input bit v, input logic [DW-1:0] d, input bit dr, input bit clr);
        bus.in_valid     = v;
        bus.in_data      = d;
        bus.drain_en     = dr;
        bus.clr_overflow = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset            = 1'b1;
        bus.in_valid     = 1'b0;
        bus.in_data      = '0;
        bus.drain_en     = 1'b0;
        bus.clr_overflow = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Three pushes with draining held off; head must be 0x11.
        cyc(1, 8'h11, 0, 0);
        cyc(1, 8'h22, 0, 0);
        cyc(1, 8'h33, 0, 0);
        cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 0, 0);
        check("dir_count3", 32'(bus.count), 32'd3);

        // Empty out, then fill with A0..A3 and offer 0xFF while full.
        repeat (3) cyc(0, 8'h00, 1, 0);
        for (int i = 0; i < 4; i++) cyc(1, 8'hA0 + 8'(i), 0, 0);
        cyc(1, 8'hFF, 0, 0);
        check("dir_full", 32'(bus.full), 32'd1);
`ifdef WRQ_OVERFLOW_FLAG_EN
        check("dir_ovf_set", 32'(bus.overflow), 32'd1);
`else
        check("dir_ovf_off", 32'(bus.overflow), 32'd0);
`endif
        // Set and clear together: set wins; then a plain clear.
        cyc(1, 8'hFE, 0, 1);
        cyc(0, 8'h00, 0, 1);
        check("dir_ovf_clr", 32'(bus.overflow), 32'd0);

        // Drain four in order, ending empty.
        repeat (4) cyc(0, 8'h00, 1, 0);
        check("dir_drained", 32'(bus.empty), 32'd1);

        // Steady stream from count=2 for 10 words: pointers wrap twice.
        cyc(1, 8'h50, 0, 0);
        cyc(1, 8'h51, 0, 0);
        for (int i = 0; i < 10; i++) cyc(1, 8'h60 + 8'(i), 1, 0);
        check("dir_stream_cnt", 32'(bus.count), 32'd2);
        repeat (2) cyc(0, 8'h00, 1, 0);

        // Push into empty while draining: no bypass, strobe the next cycle.
        bus.in_valid = 1'b1; bus.in_data = 8'h77; bus.drain_en = 1'b1;
        #1;
        check("no_bypass_we", 32'(bus.write_enable), 32'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        #1;
        check("next_we", 32'(bus.write_enable), 32'd1);
        check("next_data", 32'(bus.write_port_1), 32'h77);
        @(posedge clk); #1;

        // Fill, overflow, drop to three, then reset asynchronously mid-cycle.
        for (int i = 0; i < 4; i++) cyc(1, 8'hC0 + 8'(i), 0, 0);
        cyc(1, 8'hEE, 0, 0);
        cyc(0, 8'h00, 1, 0);
        bus.drain_en = 1'b1;
        #2;
        reset = 1'b1;
        sb.delete();
        occ = 0;
        ovf = 1'b0;
        #1;
        check("arst_count", 32'(bus.count),        32'd0);
        check("arst_empty", 32'(bus.empty),        32'd1);
        check("arst_we",    32'(bus.write_enable), 32'd0);
        check("arst_ovf",   32'(bus.overflow),     32'd0);
        check("arst_port",  32'(bus.write_port_1), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 99) < 60,
                DW'($urandom),
                $urandom_range(0, 99) < 50,
                $urandom_range(0, 99) < 10);
        end
        repeat (DEPTH + 1) cyc(0, 8'h00, 1, 0);
        check("final_empty", 32'(bus.empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
